dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (RAM plus the memory-mapped peripheral window) between two requesters.
- Requester 1 is the pipeline MEM stage. Requester 2 is a debug/loader port used to inspect or preload RAM at run time.
- The CPU has fixed priority. The debug side is protected against starvation by a wait counter that forces a one-cycle CPU stall.
- Sits between the MEM stage and the data memory; the memory's combinational read path is unchanged.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 32, byte-address width.
- STARVE_LIMIT, 4, consecutive cycles a pending debug request may lose before it is forced (legal range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- cpu_req  in  1  MEM stage wants memory this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  combinational read data to the CPU.
- cpu_stall  out  1  CPU must hold its MEM stage this cycle.
- dbg_req  in  1  debug transaction request (level).
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_rdata  out  DATA_W  registered debug read data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_err  out  1  qualifies dbg_ack; access refused.
- mem_addr  out  ADDR_W  address to the data memory.
- mem_wdata  out  DATA_W  write data to the data memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DATA_W  combinational memory read data.

Behaviour:
- Reset: when reset is low, asynchronously go to IDLE. Counter = 0. dbg_rdata = 0, dbg_ack = 0, dbg_err = 0. Latched debug request = 0.
- Reset mid-transaction: the transaction is aborted; no write is issued after reset.
- FSM states: IDLE, WAIT, FORCE, ACK.
- IDLE:
  - CPU owns the port.
  - If dbg_req = 1: latch dbg_we/addr/wdata, clear the counter, go to WAIT.
  - If the latched address has bit 30 = 1 (peripheral space), go straight to ACK with dbg_err = 1; no memory access is made.
- WAIT, cpu_req = 0: debug owns the port this cycle. Capture mem_rdata into dbg_rdata (reads only), then go to ACK.
- WAIT, cpu_req = 1: CPU owns the port and the counter increments. When counter reaches STARVE_LIMIT-1 with cpu_req still high, go to FORCE.
- FORCE:
  - Debug owns the port for exactly one cycle; capture as in WAIT; go to ACK.
  - cpu_stall = cpu_req in this cycle.
- ACK:
  - dbg_ack = 1 for one cycle; dbg_err is valid alongside it.
  - CPU owns the port; go to IDLE.
  - The requester must drop dbg_req in the ACK cycle. If dbg_req is still high in IDLE, it is treated as a new transaction.
- cpu_stall is 1 only in FORCE with cpu_req = 1; 0 in all other states and at reset.
- Port mux when the CPU owns the port:
  - mem_* driven from cpu_*.
  - mem_read = cpu_req & ~cpu_we; mem_write = cpu_req & cpu_we.
  - cpu_rdata = mem_rdata when mem_read = 1, else 0.
- Port mux when debug owns the port:
  - mem_* driven from the latched debug request.
  - The cpu_* strobes are suppressed and cpu_rdata = 0.
- dbg_rdata keeps its value until the next debug read capture. A debug write leaves dbg_rdata unchanged.
- Latency:
  - Debug with the CPU idle: ack 2 cycles after the request is accepted in IDLE.
  - Worst case: STARVE_LIMIT + 2 cycles.
- Simultaneous cpu_req and dbg_req in IDLE: the CPU is served; debug enters WAIT.
- Counter saturates and cannot wrap, because the FSM always leaves WAIT at the limit.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit constants ST_IDLE/ST_WAIT/ST_FORCE/ST_ACK).
  - PERIPH_BIT = 30.
  - Default STARVE_LIMIT.
- No sub-module. The FSM, counter and output mux stay in one module; the port mux is a combinational block selected by a debug-owns-port signal.

Test Plan:
- Debug read, CPU idle: dbg_req with addr 0x0000_0010, RAM word 4 = 145 -> mem_read from debug in WAIT; dbg_ack next cycle with dbg_rdata = 145, dbg_err = 0; cpu_stall never asserts.
- Debug write, CPU idle: write 0xDEAD_BEEF to addr 0x8; then CPU reads 0x8 -> cpu_rdata = 0xDEAD_BEEF. dbg_rdata unchanged by the write.
- Starvation, CPU busy: cpu_req held high, debug read of addr 0x0 -> exactly 4 WAIT cycles with CPU served; FORCE cycle with cpu_stall = 1 and mem_addr = 0x0; dbg_ack the following cycle with dbg_rdata = 92.
- Collision: cpu_req and dbg_req rise together -> CPU write completes first. Debug completes in the first cycle cpu_req = 0. No cycle has both sources strobing.
- Peripheral refusal: dbg_addr = 0x4000_0000 -> dbg_ack with dbg_err = 1 two cycles later; mem_read/mem_write stay 0 for debug.
- Reset abort: reset driven low during FORCE of a debug write -> no mem_write; all outputs 0 immediately. After release, state is IDLE and the CPU is served normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, address map
// constants and the default starvation limit.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Address bit that selects the memory-mapped peripheral window.
  localparam int PERIPH_BIT = 30;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the data-memory arbiter.
// The slave view belongs to the arbiter; the master view is its surroundings.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic              dbg_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack, dbg_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack, dbg_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and a
// debug/loader port that is protected from starvation by a forced CPU stall.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              lat_periph;
  logic              dbg_owns;
  logic              cpu_rd;

  assign accept     = (state == ST_IDLE) && bus.dbg_req;
  assign lat_periph = lat_addr[PERIPH_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dbg_owns  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.dbg_req) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Peripheral-window requests are refused without touching memory.
        if (lat_periph) begin
          state_nxt = ST_ACK;
        end else if (!bus.cpu_req) begin
          dbg_owns  = 1'b1;
          state_nxt = ST_ACK;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        dbg_owns  = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter stops at the limit; WAIT is always left from there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == ST_WAIT) && bus.cpu_req && !lat_periph && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= bus.dbg_we;
      lat_addr  <= bus.dbg_addr;
      lat_wdata <= bus.dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state == ST_WAIT) && lat_periph) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (dbg_owns && !lat_we) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // Port mux; everything is held quiet while reset is asserted so an
  // interrupted write cannot reach memory.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.cpu_rdata = '0;
    cpu_rd        = 1'b0;
    if (reset) begin
      if (dbg_owns) begin
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        bus.mem_read  = ~lat_we;
        bus.mem_write = lat_we;
      end else begin
        cpu_rd        = bus.cpu_req & ~bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_read  = cpu_rd;
        bus.mem_write = bus.cpu_req & bus.cpu_we;
        bus.cpu_rdata = cpu_rd ? bus.mem_rdata : '0;
      end
    end
  end

  assign bus.cpu_stall = (state == ST_FORCE) && bus.cpu_req;
  assign bus.dbg_ack   = (state == ST_ACK);
  assign bus.dbg_err   = (state == ST_ACK) && err_q;
  assign bus.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed RAM model on the
// memory side.
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dmem_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .STARVE_LIMIT(4),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [0:15];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
      mem[0]     <= 32'd92;
      mem[3]     <= 32'h33;
      mem[4]     <= 32'd145;
      mem_loaded <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 32'h0;
    bus.dbg_wdata = 32'h0;

    // reset state
    repeat (2) next_cycle;
    settle;
    check("rst_ack",   32'(bus.dbg_ack),   32'd0);
    check("rst_err",   32'(bus.dbg_err),   32'd0);
    check("rst_rdata", bus.dbg_rdata,      32'd0);
    check("rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_mread", 32'(bus.mem_read),  32'd0);
    reset = 1'b1;
    next_cycle;

    // debug read, CPU idle
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 32'h10;
    settle;
    check("t1_idle_stall", 32'(bus.cpu_stall), 32'd0);
    next_cycle;
    bus.dbg_req = 1'b0;
    settle;
    check("t1_wait_rd",    32'(bus.mem_read),  32'd1);
    check("t1_wait_wr",    32'(bus.mem_write), 32'd0);
    check("t1_wait_addr",  bus.mem_addr,       32'h10);
    check("t1_wait_crd",   bus.cpu_rdata,      32'd0);
    check("t1_wait_ack",   32'(bus.dbg_ack),   32'd0);
    check("t1_wait_stall", 32'(bus.cpu_stall), 32'd0);
    next_cycle;
    settle;
    check("t1_ack",       32'(bus.dbg_ack),   32'd1);
    check("t1_err",       32'(bus.dbg_err),   32'd0);
    check("t1_rdata",     bus.dbg_rdata,      32'd145);
    check("t1_ack_stall", 32'(bus.cpu_stall), 32'd0);
    next_cycle;
    settle;
    check("t1_ack_drop", 32'(bus.dbg_ack), 32'd0);

    // debug write, CPU idle, then CPU reads it back
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h8;
    bus.dbg_wdata = 32'hDEAD_BEEF;
    next_cycle;
    bus.dbg_req = 1'b0;
    settle;
    check("t2_wr",    32'(bus.mem_write), 32'd1);
    check("t2_rd",    32'(bus.mem_read),  32'd0);
    check("t2_addr",  bus.mem_addr,       32'h8);
    check("t2_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
    next_cycle;
    settle;
    check("t2_ack",   32'(bus.dbg_ack), 32'd1);
    check("t2_rdata", bus.dbg_rdata,    32'd145);
    next_cycle;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h8;
    settle;
    check("t2_cpu_rd",   32'(bus.mem_read), 32'd1);
    check("t2_cpu_addr", bus.mem_addr,      32'h8);
    check("t2_cpu_rdata", bus.cpu_rdata,    32'hDEAD_BEEF);

    // starvation: CPU busy reading 0x10, debug reads 0x0
    next_cycle;
    bus.cpu_addr = 32'h10;
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 32'h0;
    settle;
    check("t3_idle_crd", bus.cpu_rdata, 32'd145);
    next_cycle;
    bus.dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle;
      check("t3_wait_stall", 32'(bus.cpu_stall), 32'd0);
      check("t3_wait_addr",  bus.mem_addr,       32'h10);
      check("t3_wait_crd",   bus.cpu_rdata,      32'd145);
      check("t3_wait_ack",   32'(bus.dbg_ack),   32'd0);
      next_cycle;
    end
    settle;
    check("t3_force_stall", 32'(bus.cpu_stall), 32'd1);
    check("t3_force_addr",  bus.mem_addr,       32'h0);
    check("t3_force_rd",    32'(bus.mem_read),  32'd1);
    check("t3_force_crd",   bus.cpu_rdata,      32'd0);
    next_cycle;
    settle;
    check("t3_ack",       32'(bus.dbg_ack),   32'd1);
    check("t3_rdata",     bus.dbg_rdata,      32'd92);
    check("t3_ack_stall", 32'(bus.cpu_stall), 32'd0);
    check("t3_ack_crd",   bus.cpu_rdata,      32'd145);
    next_cycle;
    bus.cpu_req = 1'b0;

    // collision: CPU write and debug read of the same word together
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h14;
    bus.cpu_wdata = 32'h5555_AAAA;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 32'h14;
    settle;
    check("t4_cpu_wr",    32'(bus.mem_write), 32'd1);
    check("t4_cpu_rd",    32'(bus.mem_read),  32'd0);
    check("t4_cpu_wdata", bus.mem_wdata,      32'h5555_AAAA);
    next_cycle;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.dbg_req = 1'b0;
    settle;
    check("t4_dbg_rd",   32'(bus.mem_read),  32'd1);
    check("t4_dbg_wr",   32'(bus.mem_write), 32'd0);
    check("t4_dbg_addr", bus.mem_addr,       32'h14);
    next_cycle;
    settle;
    check("t4_ack",   32'(bus.dbg_ack), 32'd1);
    check("t4_rdata", bus.dbg_rdata,    32'h5555_AAAA);
    next_cycle;

    // peripheral refusal
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h4000_0000;
    bus.dbg_wdata = 32'h77;
    next_cycle;
    bus.dbg_req = 1'b0;
    settle;
    check("t5_rd",  32'(bus.mem_read),  32'd0);
    check("t5_wr",  32'(bus.mem_write), 32'd0);
    check("t5_ack0", 32'(bus.dbg_ack),  32'd0);
    next_cycle;
    settle;
    check("t5_ack",   32'(bus.dbg_ack), 32'd1);
    check("t5_err",   32'(bus.dbg_err), 32'd1);
    check("t5_rdata", bus.dbg_rdata,    32'h5555_AAAA);
    next_cycle;
    settle;
    check("t5_ack_drop", 32'(bus.dbg_ack), 32'd0);
    check("t5_err_drop", 32'(bus.dbg_err), 32'd0);

    // reset during FORCE of a debug write
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h10;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'hC;
    bus.dbg_wdata = 32'hBAD0_0BAD;
    next_cycle;
    bus.dbg_req = 1'b0;
    repeat (4) next_cycle;
    settle;
    check("t6_force_wr",    32'(bus.mem_write), 32'd1);
    check("t6_force_stall", 32'(bus.cpu_stall), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_wr",    32'(bus.mem_write), 32'd0);
    check("t6_rst_rd",    32'(bus.mem_read),  32'd0);
    check("t6_rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("t6_rst_crd",   bus.cpu_rdata,      32'd0);
    check("t6_rst_ack",   32'(bus.dbg_ack),   32'd0);
    check("t6_rst_rdata", bus.dbg_rdata,      32'd0);
    next_cycle;
    settle;
    check("t6_mem_kept", mem[3], 32'h33);
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    next_cycle;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    settle;
    check("t6_post_rd",    32'(bus.mem_read),  32'd1);
    check("t6_post_crd",   bus.cpu_rdata,      32'd145);
    check("t6_post_stall", 32'(bus.cpu_stall), 32'd0);
    check("t6_post_ack",   32'(bus.dbg_ack),   32'd0);
    next_cycle;
    bus.cpu_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
